// File: rtl/scan_pkg.sv
// Shared types and constants for the frame scan path: sequencer state
// encoding and the per-pixel tag that travels alongside BRAM read data.
package scan_pkg;

    localparam int SCAN_DEF_WIDTH  = 320;
    localparam int SCAN_DEF_HEIGHT = 240;
    localparam int FRAME_PIXELS    = SCAN_DEF_WIDTH * SCAN_DEF_HEIGHT;
    localparam int LAST_ADDR       = FRAME_PIXELS - 1;

    // Tag coordinate fields are sized for the full camera frame; smaller
    // frames zero-extend into them.
    localparam int TAG_COL_BITS = $clog2(SCAN_DEF_WIDTH);
    localparam int TAG_ROW_BITS = $clog2(SCAN_DEF_HEIGHT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        LATCH = 2'd3
    } scan_state_t;

    typedef struct packed {
        logic                    valid;
        logic                    sof;
        logic                    eof;
        logic [TAG_COL_BITS-1:0] col;
        logic [TAG_ROW_BITS-1:0] row;
    } pix_tag_t;

endpackage

// File: rtl/delay_line.sv
// Fixed-depth shift register used to line sideband information up with
// data coming out of a pipelined memory. Cleared by reset so nothing
// in flight survives it.
module delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_stage [0:DEPTH-1];

    // Shift one stage per clock; reset empties the whole line.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/frame_scan_sequencer.sv
// Walks the frame-buffer BRAM once per accepted camera frame, producing
// read addresses plus row/column coordinates (by counting, no divide) and
// pixel strobes delayed to line up with the BRAM read latency.
module frame_scan_sequencer
    import scan_pkg::*;
#(
    parameter int IMAGE_WIDTH  = SCAN_DEF_WIDTH,
    parameter int IMAGE_HEIGHT = SCAN_DEF_HEIGHT,
    parameter int ADDR_BITS    = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT),
    parameter int READ_LATENCY = 2,
    parameter int DECIMATION   = 1
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic                            i_enable,
    input  logic                            i_frame_ready,
    output logic [ADDR_BITS-1:0]            o_rdaddress,
    output logic                            o_rd_en,
    output logic                            o_pix_valid,
    output logic [$clog2(IMAGE_WIDTH)-1:0]  o_pix_col,
    output logic [$clog2(IMAGE_HEIGHT)-1:0] o_pix_row,
    output logic                            o_sof,
    output logic                            o_eof,
    output logic                            o_result_latch,
    output logic                            o_busy,
    output logic                            o_overrun
);

    localparam int COL_BITS = $clog2(IMAGE_WIDTH);
    localparam int ROW_BITS = $clog2(IMAGE_HEIGHT);
    localparam int DEC_BITS = 4;
    localparam int DRN_BITS = 3;

    localparam logic [ADDR_BITS-1:0] LAST_PIX_ADDR = ADDR_BITS'(IMAGE_WIDTH * IMAGE_HEIGHT - 1);
    localparam logic [COL_BITS-1:0]  LAST_COL      = COL_BITS'(IMAGE_WIDTH - 1);
    localparam logic [DEC_BITS-1:0]  LAST_DEC      = DEC_BITS'(DECIMATION - 1);
    localparam logic [DRN_BITS-1:0]  LAST_DRAIN    = DRN_BITS'(READ_LATENCY - 1);

    scan_state_t           r_state;
    scan_state_t           w_nextState;
    logic [ADDR_BITS-1:0]  r_addr;
    logic [COL_BITS-1:0]   r_col;
    logic [ROW_BITS-1:0]   r_row;
    logic [DRN_BITS-1:0]   r_drainCnt;
    logic [DEC_BITS-1:0]   r_decCnt;
    logic                  r_pending;
    logic                  r_overrun;

    logic                  w_accept;
    logic                  w_start;
    logic                  w_lastAddr;
    pix_tag_t              w_tagIn;
    pix_tag_t              w_tagOut;
    logic [$bits(pix_tag_t)-1:0] w_tagBits;
    logic                  w_unusedTagBits;

    assign w_accept   = i_frame_ready && (r_decCnt == '0);
    assign w_start    = (r_state == IDLE) && i_enable && (w_accept || r_pending);
    assign w_lastAddr = (r_addr == LAST_PIX_ADDR);

    // State register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state: scan the frame, wait out the read latency, pulse latch.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_start) w_nextState = SCAN;
            SCAN:    if (w_lastAddr) w_nextState = DRAIN;
            DRAIN:   if (r_drainCnt == LAST_DRAIN) w_nextState = LATCH;
            LATCH:   w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // State-decoded strobes.
    always_comb begin
        o_rd_en        = 1'b0;
        o_busy         = 1'b0;
        o_result_latch = 1'b0;
        o_rd_en        = (r_state == SCAN);
        o_busy         = (r_state != IDLE);
        o_result_latch = (r_state == LATCH);
    end

    // Decimation counter advances on every frame pulse, accepted or not.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_decCnt <= '0;
        end else if (i_frame_ready) begin
            r_decCnt <= (r_decCnt == LAST_DEC) ? '0 : r_decCnt + DEC_BITS'(1);
        end
    end

    // One-deep frame backlog; a frame arriving with the backlog full is dropped and flagged.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_start) begin
            r_pending <= w_accept && r_pending;
        end else if (w_accept) begin
            if (r_pending) begin
                r_overrun <= 1'b1;
            end else begin
                r_pending <= 1'b1;
            end
        end
    end

    // Address and raster coordinates; address holds its last value between scans.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_addr <= '0;
            r_col  <= '0;
            r_row  <= '0;
        end else if (w_start) begin
            r_addr <= '0;
            r_col  <= '0;
            r_row  <= '0;
        end else if ((r_state == SCAN) && !w_lastAddr) begin
            r_addr <= r_addr + ADDR_BITS'(1);
            if (r_col == LAST_COL) begin
                r_col <= '0;
                r_row <= r_row + ROW_BITS'(1);
            end else begin
                r_col <= r_col + COL_BITS'(1);
            end
        end
    end

    // Counts cycles spent in DRAIN so the last pixel leaves the BRAM before latching.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_drainCnt <= '0;
        end else if (r_state == DRAIN) begin
            r_drainCnt <= r_drainCnt + DRN_BITS'(1);
        end else begin
            r_drainCnt <= '0;
        end
    end

    // Tag for the address issued this cycle; all-zero when not scanning.
    always_comb begin
        w_tagIn = '0;
        if (r_state == SCAN) begin
            w_tagIn.valid = 1'b1;
            w_tagIn.sof   = (r_addr == '0);
            w_tagIn.eof   = w_lastAddr;
            w_tagIn.col   = TAG_COL_BITS'(r_col);
            w_tagIn.row   = TAG_ROW_BITS'(r_row);
        end
    end

    delay_line #(
        .WIDTH ($bits(pix_tag_t)),
        .DEPTH (READ_LATENCY)
    ) u_tagDelay (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_data  (w_tagIn),
        .o_data  (w_tagBits)
    );

    assign w_tagOut        = pix_tag_t'(w_tagBits);
    assign w_unusedTagBits = ^{w_tagOut.col, w_tagOut.row};

    assign o_rdaddress = r_addr;
    assign o_pix_valid = w_tagOut.valid;
    assign o_sof       = w_tagOut.sof;
    assign o_eof       = w_tagOut.eof;
    assign o_pix_col   = w_tagOut.col[COL_BITS-1:0];
    assign o_pix_row   = w_tagOut.row[ROW_BITS-1:0];
    assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_frame_scan_sequencer.sv
// Bench for frame_scan_sequencer on a small 5x3 frame. The reference model
// tracks only "cycle at which the current scan began" and derives every
// output from the offset into that scan with plain arithmetic.
module tb_frame_scan_sequencer;

    localparam int W   = 5;
    localparam int H   = 3;
    localparam int N   = W * H;
    localparam int RL  = 3;
    localparam int DEC = 2;
    localparam int AB  = $clog2(N);
    localparam int CB  = $clog2(W);
    localparam int RB  = $clog2(H);

    logic          clk;
    logic          reset;
    logic          enable;
    logic          frameReady;
    logic [AB-1:0] rdAddress;
    logic          rdEn;
    logic          pixValid;
    logic [CB-1:0] pixCol;
    logic [RB-1:0] pixRow;
    logic          sof;
    logic          eof;
    logic          resultLatch;
    logic          busy;
    logic          overrun;

    int vectors;
    int miscompares;

    int cyc;
    int scanStart;
    bit scanning;
    bit mPending;
    bit mOverrun;
    int mDec;

    frame_scan_sequencer #(
        .IMAGE_WIDTH  (W),
        .IMAGE_HEIGHT (H),
        .READ_LATENCY (RL),
        .DECIMATION   (DEC)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_enable       (enable),
        .i_frame_ready  (frameReady),
        .o_rdaddress    (rdAddress),
        .o_rd_en        (rdEn),
        .o_pix_valid    (pixValid),
        .o_pix_col      (pixCol),
        .o_pix_row      (pixRow),
        .o_sof          (sof),
        .o_eof          (eof),
        .o_result_latch (resultLatch),
        .o_busy         (busy),
        .o_overrun      (overrun)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h expected %0h (cycle %0d, t=%0t)", tag, observed, expected, cyc, $time);
        end
    endtask

    task automatic modelReset();
        cyc       = 0;
        scanStart = 0;
        scanning  = 1'b0;
        mPending  = 1'b0;
        mOverrun  = 1'b0;
        mDec      = 0;
    endtask

    function automatic bit modelBusy();
        int k;
        k = cyc - scanStart;
        return scanning && (k >= 0) && (k <= N + RL);
    endfunction

    // Advance the model across one clock edge with the inputs seen at that edge.
    task automatic modelStep(input bit fr, input bit en);
        bit idle;
        bit acc;
        idle = !modelBusy();
        acc  = fr && (mDec == 0);
        if (fr) mDec = (mDec + 1) % DEC;
        if (idle && en && (acc || mPending)) begin
            scanning  = 1'b1;
            scanStart = cyc + 1;
            mPending  = acc && mPending;
        end else if (acc) begin
            if (mPending) mOverrun = 1'b1;
            else          mPending = 1'b1;
        end
        cyc++;
    endtask

    task automatic compareAll();
        int k;
        int p;
        bit act;
        bit val;
        logic [31:0] expAddr;
        k   = cyc - scanStart;
        act = modelBusy();
        p   = k - RL;
        val = act && (p >= 0) && (p < N);
        if (!scanning)  expAddr = 0;
        else if (k < N) expAddr = k;
        else            expAddr = N - 1;
        checkOutput("ctl{rd_en,busy,latch,overrun}", 32'({rdEn, busy, resultLatch, overrun}),
                    32'({act && (k < N), act, act && (k == N + RL), mOverrun}));
        checkOutput("rdaddress", 32'(rdAddress), expAddr);
        checkOutput("pix{valid,sof,eof}", 32'({pixValid, sof, eof}),
                    32'({val, val && (p == 0), val && (p == N - 1)}));
        checkOutput("pix_col", 32'(pixCol), val ? p % W : 0);
        checkOutput("pix_row", 32'(pixRow), val ? p / W : 0);
    endtask

    // Drive one cycle of inputs (called at a falling edge), clock it, then check.
    task automatic applyStimulus(input bit fr, input bit en);
        frameReady = fr;
        enable     = en;
        @(posedge clk);
        modelStep(fr, en);
        @(negedge clk);
        compareAll();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput(tag, 32'({rdAddress, rdEn, pixValid, pixCol, pixRow, sof, eof, resultLatch, busy, overrun}), 32'd0);
    endtask

    // Asynchronous reset pulse launched between clock edges.
    task automatic applyReset();
        frameReady = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checkAllZero("async_reset_outputs");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        compareAll();
    endtask

    initial begin
        bit en;
        bit reached;
        vectors     = 0;
        miscompares = 0;
        modelReset();
        reset      = 1'b1;
        enable     = 1'b0;
        frameReady = 1'b0;
        #1;
        checkAllZero("reset_state");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        compareAll();

        $display("[TB] single frame sweep");
        applyStimulus(1'b1, 1'b1);
        repeat (N + RL + 8) applyStimulus(1'b0, 1'b1);

        $display("[TB] frames arriving mid-scan");
        applyStimulus(1'b1, 1'b1);
        for (int i = 0; i < 12; i++) applyStimulus(i % 2 == 1, 1'b1);
        repeat (2 * (N + RL) + 10) applyStimulus(1'b0, 1'b1);

        $display("[TB] frame while disabled");
        for (int i = 0; i < 4; i++) applyStimulus(i % 2 == 0, 1'b0);
        repeat (10) applyStimulus(1'b0, 1'b0);
        repeat (N + RL + 6) applyStimulus(1'b0, 1'b1);

        $display("[TB] randomized traffic");
        en = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 49) == 0) en = ~en;
            applyStimulus($urandom_range(0, 9) == 0, en);
        end

        $display("[TB] reset in the middle of a scan");
        reached = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            applyStimulus(1'b1, 1'b1);
            reached = scanning && (cyc - scanStart == 7);
        end
        checkOutput("midscan_reached", 32'(reached), 32'd1);
        applyReset();
        repeat (N + RL + 4) applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        repeat (N + RL + 6) applyStimulus(1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
